// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses SYNC/LEN/payload/CSUM packets from the UART rx FIFO into frame memory,
// acknowledges them, starts the processor core and echoes the processed frame plus its checksum.
module uart_frame_ctrl #(
   parameter int unsigned ADDR_W  = 16,
   parameter logic [7:0]  SYNC    = 8'hA5,
   parameter int unsigned TIMEOUT = 5_000_000,
   parameter int unsigned TO_W    = 23
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_empty,
   input  logic [7:0]        r_data,
   output logic              rd_uart,
   input  logic              tx_full,
   output logic              wr_uart,
   output logic [7:0]        w_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata,
   output logic              proc_start,
   input  logic              proc_done,
   output logic              busy,
   output logic              frame_err
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LEN_H   = 4'd1,
      S_LEN_L   = 4'd2,
      S_PAYLOAD = 4'd3,
      S_CSUM    = 4'd4,
      S_ACK     = 4'd5,
      S_PROC    = 4'd6,
      S_TX_RD   = 4'd7,
      S_TX_WR   = 4'd8,
      S_TX_CSUM = 4'd9,
      S_NAK     = 4'd10
   } state_t;

   localparam logic [7:0]      ACK_BYTE = 8'h06;
   localparam logic [7:0]      NAK_BYTE = 8'h15;
   localparam logic [16:0]     CAP      = 17'(64'd1 << ADDR_W);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [15:0]     len_q, len_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [7:0]      sum_q, sum_d;
   logic            ovs_q, ovs_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            pop_s;
   logic            timed_s;
   logic [15:0]     len_full_s;

   // Next-state and output decode; FIFO strobes must follow the live empty/full flags.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      sum_d      = sum_q;
      ovs_d      = ovs_q;
      to_d       = '0;
      pop_s      = 1'b0;
      rd_uart    = 1'b0;
      wr_uart    = 1'b0;
      w_data     = 8'h00;
      mem_addr   = '0;
      mem_wdata  = 8'h00;
      mem_we     = 1'b0;
      proc_start = 1'b0;
      frame_err  = 1'b0;
      busy       = (state_q != S_IDLE);
      len_full_s = {len_q[15:8], r_data};
      timed_s    = (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                   (state_q == S_PAYLOAD) || (state_q == S_CSUM);

      case (state_q)
         S_IDLE: begin
            if (!rx_empty) begin
               pop_s = 1'b1;
               if (r_data == SYNC) begin
                  state_d = S_LEN_H;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LEN_H: begin
            if (!rx_empty) begin
               pop_s   = 1'b1;
               len_d   = {r_data, 8'h00};
               cnt_d   = 16'h0000;
               sum_d   = 8'h00;
               state_d = S_LEN_L;
            end else begin
               state_d = S_LEN_H;
            end
         end
         S_LEN_L: begin
            if (!rx_empty) begin
               pop_s = 1'b1;
               len_d = len_full_s;
               cnt_d = 16'h0000;
               sum_d = 8'h00;
               ovs_d = ({1'b0, len_full_s} > CAP);
               if (len_full_s == 16'h0000) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end else begin
               state_d = S_LEN_L;
            end
         end
         S_PAYLOAD: begin
            mem_addr = cnt_q[ADDR_W-1:0];
            if (!rx_empty) begin
               pop_s     = 1'b1;
               mem_wdata = r_data;
               mem_we    = !ovs_q;
               sum_d     = sum_q + r_data;
               cnt_d     = cnt_q + 16'd1;
               if (cnt_q == len_q - 16'd1) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end else begin
               state_d = S_PAYLOAD;
            end
         end
         S_CSUM: begin
            if (!rx_empty) begin
               pop_s = 1'b1;
               if ((r_data == sum_q) && !ovs_q) begin
                  state_d = S_ACK;
               end else begin
                  state_d = S_NAK;
               end
            end else begin
               state_d = S_CSUM;
            end
         end
         S_ACK: begin
            if (!tx_full) begin
               wr_uart    = 1'b1;
               w_data     = ACK_BYTE;
               proc_start = 1'b1;
               state_d    = S_PROC;
            end else begin
               state_d = S_ACK;
            end
         end
         S_NAK: begin
            if (!tx_full) begin
               wr_uart   = 1'b1;
               w_data    = NAK_BYTE;
               frame_err = 1'b1;
               state_d   = S_IDLE;
            end else begin
               state_d = S_NAK;
            end
         end
         S_PROC: begin
            if (proc_done) begin
               cnt_d = 16'h0000;
               sum_d = 8'h00;
               if (len_q == 16'h0000) begin
                  state_d = S_TX_CSUM;
               end else begin
                  state_d = S_TX_RD;
               end
            end else begin
               state_d = S_PROC;
            end
         end
         S_TX_RD: begin
            mem_addr = cnt_q[ADDR_W-1:0];
            state_d  = S_TX_WR;
         end
         S_TX_WR: begin
            // Address is held while the tx FIFO is full so mem_rdata stays valid.
            mem_addr = cnt_q[ADDR_W-1:0];
            if (!tx_full) begin
               wr_uart = 1'b1;
               w_data  = mem_rdata;
               sum_d   = sum_q + mem_rdata;
               if (cnt_q == len_q - 16'd1) begin
                  state_d = S_TX_CSUM;
               end else begin
                  cnt_d   = cnt_q + 16'd1;
                  state_d = S_TX_RD;
               end
            end else begin
               state_d = S_TX_WR;
            end
         end
         S_TX_CSUM: begin
            if (!tx_full) begin
               wr_uart = 1'b1;
               w_data  = sum_q;
               state_d = S_IDLE;
            end else begin
               state_d = S_TX_CSUM;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      rd_uart = pop_s;

      if (timed_s) begin
         if (pop_s) begin
            to_d = '0;
         end else if (to_q == TO_LAST) begin
            frame_err = 1'b1;
            state_d   = S_IDLE;
            to_d      = '0;
         end else begin
            to_d = to_q + TO_W'(1'b1);
         end
      end else begin
         to_d = '0;
      end

      // Keep the FIFOs and memory untouched while reset is held.
      if (reset) begin
         rd_uart    = 1'b0;
         wr_uart    = 1'b0;
         w_data     = 8'h00;
         mem_addr   = '0;
         mem_wdata  = 8'h00;
         mem_we     = 1'b0;
         proc_start = 1'b0;
         busy       = 1'b0;
         frame_err  = 1'b0;
      end else begin
         busy = (state_q != S_IDLE);
      end
   end

   // State, length, count, running sum, oversize flag and inter-byte timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= 16'h0000;
         cnt_q   <= 16'h0000;
         sum_q   <= 8'h00;
         ovs_q   <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         ovs_q   <= ovs_d;
         to_q    <= to_d;
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: byte-level rx/tx FIFO and memory models, frame-level scoreboard,
// directed packets from the plan plus randomized frames with rx gaps and tx backpressure.
module tb_uart_frame_ctrl;

   localparam int AW  = 6;
   localparam int TMO = 64;
   localparam int CAP = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx_empty = 1'b1;
   logic [7:0]    r_data = 8'h00;
   logic          rd_uart;
   logic          tx_full = 1'b0;
   logic          wr_uart;
   logic [7:0]    w_data;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_we;
   logic [7:0]    mem_rdata = 8'h00;
   logic          proc_start;
   logic          proc_done = 1'b0;
   logic          busy;
   logic          frame_err;

   uart_frame_ctrl #(.ADDR_W(AW), .SYNC(8'hA5), .TIMEOUT(TMO), .TO_W(23)) dut (
      .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
      .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .proc_start(proc_start),
      .proc_done(proc_done), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   logic [7:0]    rxq[$];
   logic [7:0]    exp_tx[$];
   logic [7:0]    tx_log[$];
   int            exp_wr[$];
   logic [7:0]    mem[CAP];
   int            n_cmp = 0, n_bad = 0;
   int            exp_start = 0, exp_err = 0;
   int            proc_timer = 0, cur_len = 0, cur_off = 0;
   bit            gap_en = 0, full_rand = 0, full_force = 0;
   logic          smp_pop = 1'b0, smp_we = 1'b0, smp_start = 1'b0, prev_start = 1'b0;
   logic [AW-1:0] smp_addr = '0;
   logic [7:0]    smp_wdata = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, expv);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got unexpected %0h, none required", name, act);
   endtask

   // Driver: FIFO pops, memory write/read, processor core, and input flags after each edge.
   initial begin
      foreach (mem[i]) mem[i] = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (smp_pop && rxq.size() > 0) void'(rxq.pop_front());
         if (smp_we) mem[smp_addr] = smp_wdata;
         mem_rdata = mem[smp_addr];
         if (smp_start) proc_timer = 10;
         proc_done = 1'b0;
         if (proc_timer > 0) begin
            proc_timer--;
            if (proc_timer == 0) begin
               for (int i = 0; i < cur_len; i++) mem[i] = 8'(i + 1 + cur_off);
               proc_done = 1'b1;
            end
         end
         rx_empty = (rxq.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
         r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
         tx_full  = full_force || (full_rand && $urandom_range(0, 2) == 0);
      end
   end

   // Compare process: every cycle, on the falling edge.
   initial forever begin
      @(negedge clk);
      smp_pop = rd_uart; smp_we = mem_we; smp_addr = mem_addr;
      smp_wdata = mem_wdata; smp_start = proc_start;
      if (!reset) begin
         if (rd_uart) check("rd_when_empty", 32'(rx_empty), 32'd0);
         if (wr_uart) begin
            check("wr_when_full", 32'(tx_full), 32'd0);
            tx_log.push_back(w_data);
            if (exp_tx.size() > 0) check("tx_byte", 32'(w_data), 32'(exp_tx.pop_front()));
            else unexpected("tx_byte", 32'(w_data));
         end
         if (mem_we) begin
            if (exp_wr.size() > 0) check("mem_write", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
            else unexpected("mem_write", 32'({mem_addr, mem_wdata}));
         end
         if (proc_start) begin
            check("start_width", 32'(prev_start), 32'd0);
            if (exp_start > 0) begin exp_start--; n_cmp++; end
            else unexpected("proc_start", 32'd1);
         end
         if (frame_err) begin
            if (exp_err > 0) begin exp_err--; n_cmp++; end
            else unexpected("frame_err", 32'd1);
         end
      end
      prev_start = proc_start;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // Frame-level model: what memory, tx stream and pulses must result from one packet.
   task automatic frame(input logic [7:0] pl[$], input bit use_cs, input logic [7:0] cs_in, input int off);
      int         len = pl.size();
      logic [7:0] s = 8'h00, cs, t = 8'h00, b;
      foreach (pl[i]) s += pl[i];
      cs = use_cs ? cs_in : s;
      if (len <= CAP) foreach (pl[i]) exp_wr.push_back((i << 8) | int'(pl[i]));
      if (len <= CAP && cs == s) begin
         exp_tx.push_back(8'h06);
         exp_start++;
         for (int i = 0; i < len; i++) begin
            b = 8'(i + 1 + off);
            exp_tx.push_back(b);
            t += b;
         end
         exp_tx.push_back(t);
         cur_len = len;
         cur_off = off;
      end else begin
         exp_tx.push_back(8'h15);
         exp_err++;
      end
      rxq.push_back(8'hA5);
      rxq.push_back(8'(len >> 8));
      rxq.push_back(8'(len));
      foreach (pl[i]) rxq.push_back(pl[i]);
      rxq.push_back(cs);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!(exp_tx.size() == 0 && rxq.size() == 0 && exp_err == 0 && exp_start == 0 &&
               proc_timer == 0) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check({name, "_complete"}, 32'(n < 4000), 32'd1);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_memq"}, 32'(exp_wr.size()), 32'd0);
      exp_tx.delete(); exp_wr.delete(); exp_err = 0; exp_start = 0;
   endtask

   task automatic check_log(input string name, input logic [7:0] lit[$]);
      check({name, "_txcount"}, 32'(tx_log.size()), 32'(lit.size()));
      foreach (lit[i]) if (i < tx_log.size()) check({name, "_txlit"}, 32'(tx_log[i]), 32'(lit[i]));
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_rd"}, 32'(rd_uart), 32'd0);
      check({name, "_wr"}, 32'(wr_uart), 32'd0);
      check({name, "_wdata"}, 32'(w_data), 32'd0);
      check({name, "_mem"}, 32'({mem_addr, mem_wdata, mem_we}), 32'd0);
      check({name, "_start"}, 32'(proc_start), 32'd0);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_err"}, 32'(frame_err), 32'd0);
   endtask

   initial begin
      logic [7:0] pl[$];
      logic [7:0] lit[$];
      int         n;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Valid frame, processor rewrites memory to 01 02 03.
      tx_log.delete();
      pl = '{8'h10, 8'h20, 8'h30};
      frame(pl, 1'b1, 8'h60, 0);
      wait_done("valid");
      lit = '{8'h06, 8'h01, 8'h02, 8'h03, 8'h06};
      check_log("valid", lit);

      // Bad checksum.
      tx_log.delete();
      pl = '{8'h11, 8'h22};
      frame(pl, 1'b1, 8'h00, 0);
      wait_done("badcs");
      lit = '{8'h15};
      check_log("badcs", lit);

      // Garbage then zero-length frame.
      tx_log.delete();
      rxq.push_back(8'h00);
      rxq.push_back(8'hFF);
      pl.delete();
      frame(pl, 1'b1, 8'h00, 0);
      wait_done("garbage");
      lit = '{8'h06, 8'h00};
      check_log("garbage", lit);

      // Tx backpressure held for 20 cycles during a 4-byte echo.
      tx_log.delete();
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      frame(pl, 1'b1, 8'h0A, 4);
      n = 0;
      while (tx_log.size() < 2 && n < 500) begin @(negedge clk); n++; end
      full_force = 1'b1;
      repeat (20) @(negedge clk);
      full_force = 1'b0;
      wait_done("backpressure");
      lit = '{8'h06, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A};
      check_log("backpressure", lit);

      // Timeout mid-payload, then a valid frame.
      tx_log.delete();
      rxq.push_back(8'hA5); rxq.push_back(8'h00); rxq.push_back(8'h05); rxq.push_back(8'h01);
      exp_wr.push_back((0 << 8) | 8'h01);
      exp_err++;
      wait_done("timeout");
      check("timeout_no_tx", 32'(tx_log.size()), 32'd0);
      pl = '{8'h07, 8'h09};
      frame(pl, 1'b0, 8'h00, 9);
      wait_done("after_timeout");
      lit = '{8'h06, 8'h0A, 8'h0B, 8'h15};
      check_log("after_timeout", lit);

      // Reset mid-payload, then a full frame.
      rxq.push_back(8'hA5); rxq.push_back(8'h00); rxq.push_back(8'h08);
      rxq.push_back(8'h41); rxq.push_back(8'h42); rxq.push_back(8'h43);
      exp_wr.push_back((0 << 8) | 8'h41);
      exp_wr.push_back((1 << 8) | 8'h42);
      exp_wr.push_back((2 << 8) | 8'h43);
      n = 0;
      while (rxq.size() > 0 && n < 200) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      check("midpayload_busy", 32'(busy), 32'd1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("midreset");
      check("midreset_memq", 32'(exp_wr.size()), 32'd0);
      pl = '{8'h33, 8'h44, 8'h55};
      frame(pl, 1'b0, 8'h00, 16);
      wait_done("after_reset");

      // Boundary lengths: exactly capacity (accepted) and capacity+1 (oversize, NAK).
      pl.delete();
      for (int i = 0; i < CAP; i++) pl.push_back(8'($urandom_range(0, 255)));
      frame(pl, 1'b0, 8'h00, 3);
      wait_done("len_cap");
      pl.push_back(8'h5C);
      frame(pl, 1'b0, 8'h00, 0);
      wait_done("len_oversize");

      // Randomized frames with rx gaps and tx backpressure.
      gap_en = 1; full_rand = 1;
      for (int f = 0; f < 20; f++) begin
         int         sel = $urandom_range(0, 9);
         int         len;
         logic [7:0] g;
         if (sel == 0) len = 0;
         else if (sel == 1) len = CAP;
         else if (sel == 2) len = CAP + 1 + $urandom_range(0, 5);
         else len = $urandom_range(1, 20);
         if ($urandom_range(0, 3) == 0) begin
            g = 8'($urandom_range(0, 255));
            rxq.push_back((g == 8'hA5) ? 8'h00 : g);
         end
         pl.delete();
         for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) begin
            g = 8'h00;
            foreach (pl[i]) g += pl[i];
            frame(pl, 1'b1, g + 8'($urandom_range(1, 255)), 0);
         end else begin
            frame(pl, 1'b0, 8'h00, $urandom_range(0, 255));
         end
         wait_done("random");
      end
      gap_en = 0; full_rand = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Sequencer for the UART byte-FIFO interface (rx pop, tx push) in the image-processing path. It parses framed image packets from the host, writes the payload into a byte-wide frame memory, and acknowledges each frame. It then hands the frame to the processing core and streams the processed bytes back out through the UART tx FIFO, followed by a checksum. It sits between the UART block and the frame memory / processor core.

## Interface
Parameters:
- ADDR_W, 16, frame memory address width; capacity = 2^ADDR_W bytes
- SYNC, 8'hA5, packet start byte
- TIMEOUT, 5_000_000, max clk cycles between rx bytes inside a packet
- TO_W, 23, width of timeout counter

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rx_empty  in  1  UART rx FIFO empty
- r_data  in  8  UART rx FIFO head byte, valid while rx_empty=0
- rd_uart  out  1  pop rx FIFO, single-cycle pulse
- tx_full  in  1  UART tx FIFO full
- wr_uart  out  1  push w_data into tx FIFO
- w_data  out  8  tx byte
- mem_addr  out  ADDR_W  frame memory address
- mem_wdata  out  8  write data
- mem_we  out  1  write enable
- mem_rdata  in  8  read data, valid 1 cycle after mem_addr
- proc_start  out  1  one-cycle start pulse to processor core
- proc_done  in  1  processor finished (level or pulse)
- busy  out  1  high in every state except IDLE
- frame_err  out  1  one-cycle pulse on NAK or timeout

## Operation
- Packet format (host to FPGA): SYNC, LEN_H, LEN_L, LEN payload bytes, CSUM. CSUM = 8-bit sum mod 256 of the payload.
- States: IDLE, LEN_H, LEN_L, PAYLOAD, CSUM, ACK, PROC, TX_RD, TX_WR, TX_CSUM, NAK.
- Rx consumption rule: in the states IDLE, LEN_H, LEN_L, PAYLOAD and CSUM, when rx_empty=0:
  - rd_uart=1 in that cycle;
  - r_data is captured in that same cycle;
  - state advances on that edge.
- IDLE: a popped byte not equal to SYNC is discarded and the state stays IDLE. On SYNC, go to LEN_H.
- LEN_H, LEN_L: latch the 16-bit length. Clear the address counter and the running sum.
- From LEN_L:
  - LEN=0 goes to CSUM.
  - Otherwise go to PAYLOAD.
  - LEN > 2^ADDR_W sets an internal oversize flag.
- PAYLOAD, per popped byte:
  - mem_we=1, mem_addr=count, mem_wdata=r_data; mem_we is suppressed while oversize is set.
  - Add the byte to the sum and increment count.
  - After byte LEN-1, go to CSUM.
- CSUM:
  - Popped byte == sum and no oversize: go to ACK.
  - Otherwise: go to NAK.
- ACK: when tx_full=0, push 8'h06 (wr_uart=1), pulse proc_start the same cycle, go to PROC.
- NAK: when tx_full=0, push 8'h15, pulse frame_err, go to IDLE.
- PROC: wait for proc_done=1. Then clear count and the tx sum, and go to TX_RD.
- TX_RD: drive mem_addr=count, go to TX_WR.
- TX_WR:
  - If tx_full=0: push mem_rdata and add it to the tx sum. Then if count==LEN-1 go to TX_CSUM; else increment count and go to TX_RD.
  - If tx_full=1: hold. mem_addr stays stable, so mem_rdata stays valid.
- LEN=0 path: PROC exits directly to TX_CSUM.
- TX_CSUM: when tx_full=0, push the tx sum, go to IDLE.
- Timeout:
  - In LEN_H, LEN_L, PAYLOAD and CSUM, the counter increments every cycle and clears on each pop.
  - Reaching TIMEOUT-1 gives: frame_err pulse, state goes to IDLE, no response byte.
  - The counter is cleared in all other states; PROC is never timed out.

## Timing
- Reset (sync, any state, including mid-payload or mid-tx): state=IDLE, and all outputs are 0 (rd_uart, wr_uart, w_data, mem_*, proc_start, busy, frame_err). Internal counter, sum and flags are cleared. Bytes already in the FIFOs are not touched.
- Maximum rx throughput is 1 byte per cycle: back-to-back pops while rx_empty=0.
- Tx throughput is 1 byte per 2 cycles (TX_RD then TX_WR).
- wr_uart is never asserted while tx_full=1. rd_uart is never asserted while rx_empty=1.
- proc_start is asserted for exactly 1 cycle per accepted frame.
- All arithmetic is truncated: the sum is 8-bit mod 256; count is 16-bit and compared against LEN.

## Test plan
- Valid frame: rx A5 00 03 10 20 30 60, then proc_done after 10 cycles.
  - mem writes at addresses 0..2 with data 10,20,30.
  - tx sends 06.
  - proc_start is 1 cycle wide.
  - With memory modified to 01 02 03, tx sends 01 02 03 06.
- Bad checksum: rx A5 00 02 11 22 00 -> tx sends 15, frame_err pulses once, proc_start never asserts, state returns to IDLE.
- Garbage then frame: rx 00 FF A5 00 00 00 -> leading bytes discarded; tx sends 06, then (after proc_done) 00.
- Tx backpressure: hold tx_full=1 for 20 cycles during the echo of 4 bytes -> no wr_uart while full; byte order and trailing checksum intact.
- Timeout: rx A5 00 05 01, then silence for TIMEOUT cycles -> frame_err pulse, no tx byte. A following valid frame is accepted normally.
- Reset mid-PAYLOAD: all outputs are 0 the cycle after reset. A subsequent full frame gets ACK with correct memory contents.
